ise_pixel_feeder: RTL and testbench

//  Upstream stage of the image sorting engine. Streams NUM_IMG images of
//  PIX_PER_IMG RGB pixels from a synchronous image memory into the sorter.
//  The sorter samples pixel_in every cycle its busy is low, starting on the

---
 rtl/ise_pkg.sv | 22 ++
 rtl/ise_pixel_feeder_if.sv | 28 ++
 rtl/ise_feed_fifo.sv | 46 ++++
 rtl/ise_pixel_feeder.sv | 110 +++++++++++
 tb/tb_ise_pixel_feeder.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ise_pkg.sv
// Constants and types shared between the pixel feeder and the image sorting engine.
package ise_pkg;

  localparam int unsigned PIX_PER_IMG = 16384;
  localparam int unsigned NUM_IMG     = 32;
  localparam int unsigned PIX_W       = 24;
  localparam int unsigned IMG_IDX_W   = 5;
  localparam int unsigned PIX_IDX_W   = 14;
  localparam int unsigned ADDR_W      = $clog2(NUM_IMG * PIX_PER_IMG);

  typedef enum logic [1:0] {
    ST_PRIME  = 2'd0,
    ST_STREAM = 2'd1,
    ST_FINISH = 2'd2
  } feed_state_t;

  typedef struct packed {
    logic [IMG_IDX_W-1:0] img_idx;
    logic [PIX_W-1:0]     pix;
  } feed_entry_t;

endpackage

// File: rtl/ise_pixel_feeder_if.sv
// Image-memory read port plus sorter pixel port of the feeder.
// master = feeder side, slave = memory/sorter side.
interface ise_pixel_feeder_if #(
  parameter int unsigned ADDR_W = ise_pkg::ADDR_W,
  parameter int unsigned PIX_W  = ise_pkg::PIX_W,
  parameter int unsigned IDX_W  = ise_pkg::IMG_IDX_W
);

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [PIX_W-1:0]  mem_rdata;
  logic              ise_reset;
  logic              ise_busy;
  logic [PIX_W-1:0]  pixel_in;
  logic [IDX_W-1:0]  image_in_index;
  logic              done;

  modport master (
    output mem_rd, mem_addr, ise_reset, pixel_in, image_in_index, done,
    input  mem_rdata, ise_busy
  );

  modport slave (
    input  mem_rd, mem_addr, ise_reset, pixel_in, image_in_index, done,
    output mem_rdata, ise_busy
  );

endinterface

// File: rtl/ise_feed_fifo.sv
// Two-entry prefetch FIFO; push and pop may happen in the same cycle.
// Head is a direct register read, so it is valid the cycle after the push.
module ise_feed_fifo #(
  parameter int unsigned W = 29
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         wr_sel;
  logic         rd_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0  <= '0;
      slot1  <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_sel) slot1 <= push_dat;
        else        slot0 <= push_dat;
        wr_sel <= ~wr_sel;
      end
      if (pop) begin
        rd_sel <= ~rd_sel;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = rd_sel ? slot1 : slot0;

endmodule

// File: rtl/ise_pixel_feeder.sv
// Streams every image pixel from synchronous memory into the sorter, holding the
// sorter in reset until two pixels are prefetched so a pixel is ready on every non-busy cycle.
module ise_pixel_feeder #(
  parameter int unsigned PIX_PER_IMG = ise_pkg::PIX_PER_IMG,
  parameter int unsigned NUM_IMG     = ise_pkg::NUM_IMG
) (
  input logic                clk,
  input logic                reset,
  ise_pixel_feeder_if.master bus
);
  import ise_pkg::*;

  localparam int unsigned TOTAL     = NUM_IMG * PIX_PER_IMG;
  localparam int unsigned ADDR_W    = $clog2(TOTAL);
  localparam int unsigned PTR_W     = ADDR_W + 1;
  localparam int unsigned PIX_SEL_W = $clog2(PIX_PER_IMG);
  localparam logic [PTR_W-1:0]  PTR_END  = PTR_W'(TOTAL);
  localparam logic [ADDR_W-1:0] LAST_POP = ADDR_W'(TOTAL - 1);

  feed_state_t           state;
  logic [PTR_W-1:0]      rd_ptr;
  logic [ADDR_W-1:0]     pop_cnt;
  logic                  inflight;
  logic [IMG_IDX_W-1:0]  inflight_idx;
  logic                  ise_reset_q;
  logic                  done_q;

  logic [1:0]            fifo_count;
  feed_entry_t           head;
  feed_entry_t           push_entry;
  logic                  pop;
  logic                  issue;
  logic [2:0]            occupancy;
  logic [IMG_IDX_W-1:0]  issue_img;

  // Reads are throttled so FIFO contents plus the outstanding read never exceed two.
  always_comb begin
    pop        = (state == ST_STREAM) && !ise_reset_q && !bus.ise_busy;
    occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    issue      = !reset && (state != ST_FINISH) && (rd_ptr < PTR_END) &&
                 (occupancy < (3'd2 + {2'b00, pop}));
    issue_img  = IMG_IDX_W'(rd_ptr[ADDR_W-1:PIX_SEL_W]);
    push_entry = '{img_idx: inflight_idx, pix: bus.mem_rdata};
  end

  ise_feed_fifo #(
    .W($bits(feed_entry_t))
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_dat (push_entry),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_PRIME;
      rd_ptr       <= '0;
      pop_cnt      <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      ise_reset_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_ptr       <= rd_ptr + PTR_W'(1);
        inflight_idx <= issue_img;
      end
      case (state)
        ST_PRIME: begin
          // Release the sorter on the same edge that lands the second pixel.
          if (inflight && (fifo_count == 2'd1)) begin
            state       <= ST_STREAM;
            ise_reset_q <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (pop) begin
            pop_cnt <= pop_cnt + ADDR_W'(1);
            if (pop_cnt == LAST_POP) begin
              state  <= ST_FINISH;
              done_q <= 1'b1;
            end
          end
        end
        ST_FINISH: begin
          state <= ST_FINISH;
        end
        default: begin
          state <= ST_PRIME;
        end
      endcase
    end
  end

  assign bus.mem_rd         = issue;
  assign bus.mem_addr       = rd_ptr[ADDR_W-1:0];
  assign bus.ise_reset      = ise_reset_q;
  assign bus.done           = done_q;
  assign bus.pixel_in       = head.pix;
  assign bus.image_in_index = head.img_idx;

  underflow_chk: assert property (@(posedge clk) disable iff (reset)
    pop |-> (fifo_count != 2'd0));

endmodule

// File: tb/tb_ise_pixel_feeder.sv
// Scoreboard bench for ise_pixel_feeder on a reduced geometry (32 images x 32 pixels).
module tb_ise_pixel_feeder;

  localparam int PPI   = 32;
  localparam int NIMG  = 32;
  localparam int TOTAL = PPI * NIMG;
  localparam int AW    = 10;
  localparam int PW    = 24;

  typedef struct packed {
    logic [4:0]  idx;
    logic [23:0] pix;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ise_pixel_feeder_if #(.ADDR_W(AW), .PIX_W(PW), .IDX_W(5)) bus();

  ise_pixel_feeder #(.PIX_PER_IMG(PPI), .NUM_IMG(NIMG)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   pops;
  int   issued;
  bit   done_pending;
  bit   done_seen;
  bit   prev_busy;
  logic [23:0] held_pix;
  logic [4:0]  held_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory returns its own address as the pixel, one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= PW'(bus.mem_addr);
  end

  task automatic load_expected();
    exp_q.delete();
    for (int a = 0; a < TOTAL; a++) exp_q.push_back({5'(a / PPI), 24'(a)});
  endtask

  task automatic clear_mon();
    pops = 0;
    issued = 0;
    done_pending = 1'b0;
    done_seen = 1'b0;
    prev_busy = 1'b0;
  endtask

  // Monitor: predicts each consumption from the pins and checks it against the queue.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0;
    end else begin
      if (done_pending) begin
        chk("done", bus.done, 1);
        chk("last_idx", bus.image_in_index, 31);
        chk("rd_after_done", bus.mem_rd, 0);
        done_pending = 1'b0;
        done_seen = 1'b1;
      end
      if (!bus.ise_reset && !bus.done) begin
        chk("prefetch_depth", (issued - pops) <= 2, 1);
      end
      if (bus.mem_rd) begin
        chk("rd_bound", issued < TOTAL, 1);
        chk("rd_addr", bus.mem_addr, issued);
        issued++;
      end
      if (!bus.ise_reset && !bus.done) begin
        if (!bus.ise_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=pixel %0h required=no pop", bus.pixel_in);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("pixel", bus.pixel_in, e.pix);
            chk("index", bus.image_in_index, e.idx);
          end
          pops++;
          if (pops == TOTAL) done_pending = 1'b1;
          prev_busy = 1'b0;
        end else begin
          if (prev_busy) begin
            chk("hold_pix", bus.pixel_in, held_pix);
            chk("hold_idx", bus.image_in_index, held_idx);
          end
          held_pix = bus.pixel_in;
          held_idx = bus.image_in_index;
          prev_busy = 1'b1;
        end
      end
    end
  end

  task automatic check_reset_state();
    chk("rst_mem_rd", bus.mem_rd, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_ise_reset", bus.ise_reset, 1);
    chk("rst_pixel", bus.pixel_in, 0);
    chk("rst_index", bus.image_in_index, 0);
    chk("rst_done", bus.done, 0);
  endtask

  // Called with reset high; releases it and measures cycles until the sorter is let go.
  task automatic start_run();
    int lat;
    load_expected();
    clear_mon();
    bus.ise_busy = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("first_rd", bus.mem_rd, 1);
    chk("first_addr", bus.mem_addr, 0);
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.ise_reset) break;
    end
    chk("release_latency", lat, 3);
  endtask

  initial begin
    bus.ise_busy = 1'b0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();

    // Per-image busy pattern with 1, 2 and 50-cycle stalls early in the first images.
    start_run();
    for (int g = 0; g < 20000 && !done_seen; g++) begin
      bus.ise_busy = ((g % (PPI + 12)) >= PPI) || (g == 5) ||
                     (g >= 10 && g <= 11) || (g >= 15 && g <= 64);
      @(posedge clk);
      #1;
    end
    chk("run_a_complete", done_seen, 1);
    chk("run_a_pops", pops, TOTAL);
    chk("run_a_reads", issued, TOTAL);

    // Reset in the middle of a run, then restart from address 0.
    reset = 1'b1;
    #1;
    check_reset_state();
    start_run();
    for (int g = 0; g < 5000 && pops < 500; g++) begin
      @(posedge clk);
      #1;
    end
    chk("run_b_reached", pops, 500);
    reset = 1'b1;
    #1;
    chk("mid_ise_reset", bus.ise_reset, 1);
    chk("mid_mem_rd", bus.mem_rd, 0);
    chk("mid_index", bus.image_in_index, 0);
    chk("mid_pixel", bus.pixel_in, 0);
    @(posedge clk);
    #1;

    // Restarted run with random 50% busy toggling.
    start_run();
    for (int g = 0; g < 20000 && !done_seen; g++) begin
      bus.ise_busy = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    chk("run_c_complete", done_seen, 1);
    chk("run_c_pops", pops, TOTAL);
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
